mem_io_bridge: RTL and testbench

Parametrised memory/IO bridge between the CPU datapath and the board peripherals. It decodes load/store addresses into data memory or a memory-mapped IO window and returns load data to the register file. Inputs are synchronised, the confirm button is debounced into a read-to-clear press flag, and the LED bank is held in a register. A sticky error flag records accesses to unmapped IO addresses.

---
 rtl/mem_io_bridge.sv | 170 +++++++++++++++++
 tb/tb_mem_io_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: load/store address decode, memory-mapped LED/switch/button/index window.
// Optional MEMIO_CYCCNT_EN adds a free-running cycle counter readable at IO offset 0x8.
module mem_io_bridge #(
  parameter logic [31:0] IO_BASE  = 32'hFFFFFC60,
  parameter int unsigned LED_W    = 16,
  parameter int unsigned SW_W     = 16,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned DB_LIMIT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_read,
  input  logic             m_write,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      m_rdata,
  input  logic [31:0]      r_rdata,
  input  logic [SW_W-1:0]  sw_in,
  input  logic             btn_confirm,
  input  logic [IDX_W-1:0] idx_in,
  output logic [31:0]      addr_out,
  output logic [31:0]      r_wdata,
  output logic [31:0]      write_data,
  output logic             mem_we,
  output logic [LED_W-1:0] led_out,
  output logic             led_ctrl,
  output logic             switch_ctrl,
  output logic             io_err
);

  localparam int unsigned      CntW   = $clog2(DB_LIMIT);
  localparam logic [CntW-1:0]  CntMax = CntW'(DB_LIMIT - 1);

  logic [31:0]      offset;
  logic             sel_led, sel_sw, sel_st, sel_idx;
  logic             rd_mapped;
  logic [31:0]      io_rdata;

  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [IDX_W-1:0] idx_meta_q, idx_sync_q;
  logic             btn_meta_q, btn_sync_q;
  logic             stable_q, stable_d;
  logic [CntW-1:0]  db_cnt_q, db_cnt_d;
  logic             flag_q, flag_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             err_q, err_d;

  // Memory reads are selected purely by the absence of io_read.
  logic unused_m_read;
  assign unused_m_read = m_read;

  assign offset  = addr_in - IO_BASE;
  assign sel_led = (offset == 32'h0);
  assign sel_sw  = (offset == 32'h2);
  assign sel_st  = (offset == 32'h3);
  assign sel_idx = (offset == 32'h4);

`ifdef MEMIO_CYCCNT_EN
  logic        sel_cyc;
  logic [31:0] cyc_q;

  assign sel_cyc = (offset == 32'h8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'h0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`endif

  always_comb begin
    io_rdata  = 32'h0;
    rd_mapped = 1'b1;
    if (sel_led) begin
      io_rdata = 32'(led_q);
    end else if (sel_sw) begin
      io_rdata = 32'(sw_sync_q);
    end else if (sel_st) begin
      io_rdata = {31'b0, flag_q};
    end else if (sel_idx) begin
      io_rdata = 32'(idx_sync_q);
`ifdef MEMIO_CYCCNT_EN
    end else if (sel_cyc) begin
      io_rdata = cyc_q;
`endif
    end else begin
      rd_mapped = 1'b0;
    end
  end

  assign addr_out    = addr_in;
  assign mem_we      = m_write;
  assign write_data  = (m_write || io_write) ? r_rdata : 32'h0;
  assign r_wdata     = io_read ? io_rdata : m_rdata;
  assign led_ctrl    = io_write && sel_led;
  assign switch_ctrl = io_read && sel_sw;
  assign led_out     = led_q;
  assign io_err      = err_q;

  // Debounce: stable only follows the synchronised button after DB_LIMIT differing cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (btn_sync_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CntMax) begin
      stable_d = btn_sync_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CntW'(1);
    end
  end

  // A set on the same edge as a read-to-clear wins.
  always_comb begin
    flag_d = flag_q;
    if (io_read && sel_st) begin
      flag_d = 1'b0;
    end
    if (stable_d && !stable_q) begin
      flag_d = 1'b1;
    end
  end

  always_comb begin
    led_d = led_q;
    if (io_write && sel_led) begin
      led_d = r_rdata[LED_W-1:0];
    end
  end

  always_comb begin
    err_d = err_q;
    if ((io_read && !rd_mapped) || (io_write && !sel_led)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      idx_meta_q <= '0;
      idx_sync_q <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      flag_q     <= 1'b0;
      led_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      idx_meta_q <= idx_in;
      idx_sync_q <= idx_meta_q;
      btn_meta_q <= btn_confirm;
      btn_sync_q <= btn_meta_q;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      flag_q     <= flag_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge with DB_LIMIT=4; load results go through a scoreboard queue.
module tb_mem_io_bridge;

  localparam logic [31:0] Base = 32'hFFFFFC60;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_read, m_write, io_read, io_write;
  logic [31:0] addr_in, m_rdata, r_rdata;
  logic [15:0] sw_in;
  logic        btn_confirm;
  logic [2:0]  idx_in;
  logic [31:0] addr_out, r_wdata, write_data;
  logic        mem_we;
  logic [15:0] led_out;
  logic        led_ctrl, switch_ctrl, io_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  mem_io_bridge #(
    .IO_BASE (Base),
    .LED_W   (16),
    .SW_W    (16),
    .IDX_W   (3),
    .DB_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_read     (m_read),
    .m_write    (m_write),
    .io_read    (io_read),
    .io_write   (io_write),
    .addr_in    (addr_in),
    .m_rdata    (m_rdata),
    .r_rdata    (r_rdata),
    .sw_in      (sw_in),
    .btn_confirm(btn_confirm),
    .idx_in     (idx_in),
    .addr_out   (addr_out),
    .r_wdata    (r_wdata),
    .write_data (write_data),
    .mem_we     (mem_we),
    .led_out    (led_out),
    .led_ctrl   (led_ctrl),
    .switch_ctrl(switch_ctrl),
    .io_err     (io_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic idle();
    m_read   = 1'b0;
    m_write  = 1'b0;
    io_read  = 1'b0;
    io_write = 1'b0;
    addr_in  = 32'h0;
    m_rdata  = 32'h0;
    r_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    sw_in = '0;
    idx_in = '0;
    btn_confirm = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (led_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_led: got %h want 0000", led_out);
    end
    n_tests++;
    if (io_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b want 0", io_err);
    end
    n_tests++;
    if (write_data !== 32'h0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_wd: got %h/%b want 0/0", write_data, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    io_read = 1'b1;
    addr_in = Base + 32'h3;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL reset_status: got %h want %h", r_wdata, exp);
    end
  endtask

  task automatic test_led();
    @(negedge clk);
    idle();
    io_write = 1'b1;
    addr_in  = Base;
    r_rdata  = 32'h0000A5A5;
    #1;
    n_tests++;
    if (led_ctrl !== 1'b1 || write_data !== 32'h0000A5A5 || led_out !== 16'h0) begin
      n_fail++;
      $display("FAIL led_write_cycle: ctrl=%b wd=%h led=%h want 1/0000a5a5/0000",
               led_ctrl, write_data, led_out);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (led_out !== 16'hA5A5 || led_ctrl !== 1'b0) begin
      n_fail++; $display("FAIL led_after_edge: led=%h ctrl=%b want a5a5/0", led_out, led_ctrl);
    end
    @(negedge clk);
    io_read = 1'b1;
    addr_in = Base;
    exp_q.push_back(32'h0000A5A5);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL led_read: got %h want %h", r_wdata, exp);
    end
    // Upper store bits must be dropped.
    @(negedge clk);
    idle();
    io_write = 1'b1;
    addr_in  = Base;
    r_rdata  = 32'hFFFF3C3C;
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (led_out !== 16'h3C3C) begin
      n_fail++; $display("FAIL led_trunc: got %h want 3c3c", led_out);
    end
    // Simultaneous read and write: read sees the old value, write lands on the edge.
    @(negedge clk);
    io_read  = 1'b1;
    io_write = 1'b1;
    addr_in  = Base;
    r_rdata  = 32'h00001111;
    exp_q.push_back(32'h00003C3C);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL led_rw_read: got %h want %h", r_wdata, exp);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (led_out !== 16'h1111) begin
      n_fail++; $display("FAIL led_rw_write: got %h want 1111", led_out);
    end
  endtask

  task automatic test_switch_idx();
    @(negedge clk);
    idle();
    sw_in  = 16'h1234;
    idx_in = 3'd5;
    @(negedge clk);
    io_read = 1'b1;
    addr_in = Base + 32'h2;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL sw_one_edge: got %h want %h", r_wdata, exp);
    end
    @(negedge clk);
    exp_q.push_back(32'h00001234);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp || switch_ctrl !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_read: got %h ctrl=%b want %h ctrl=1", r_wdata, switch_ctrl, exp);
    end
    @(negedge clk);
    addr_in = Base + 32'h4;
    exp_q.push_back(32'h00000005);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp || switch_ctrl !== 1'b0) begin
      n_fail++;
      $display("FAIL idx_read: got %h ctrl=%b want %h ctrl=0", r_wdata, switch_ctrl, exp);
    end
  endtask

  task automatic read_status(input logic [31:0] want, input string name);
    @(negedge clk);
    idle();
    io_read = 1'b1;
    addr_in = Base + 32'h3;
    exp_q.push_back(want);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL %s: got %h want %h", name, r_wdata, exp);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_debounce();
    @(negedge clk);
    idle();
    btn_confirm = 1'b1;
    repeat (2) @(negedge clk);
    btn_confirm = 1'b0;
    repeat (10) @(negedge clk);
    read_status(32'h0, "db_glitch");
    btn_confirm = 1'b1;
    repeat (10) @(negedge clk);
    btn_confirm = 1'b0;
    repeat (10) @(negedge clk);
    read_status(32'h1, "db_hold");
    read_status(32'h0, "db_cleared");
  endtask

  task automatic test_flag_coincide();
    @(negedge clk);
    idle();
    btn_confirm = 1'b1;
    // Stable rises on edge 6 after the pin; read across edge 6 so set and clear coincide.
    repeat (5) @(negedge clk);
    io_read = 1'b1;
    addr_in = Base + 32'h3;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (r_wdata !== exp) begin
        n_fail++; $display("FAIL flag_coincide[%0d]: got %h want %h", i, r_wdata, exp);
      end
      @(negedge clk);
    end
    idle();
    btn_confirm = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (io_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clean: got %b want 0", io_err);
    end
  endtask

  task automatic test_mem();
    @(negedge clk);
    idle();
    m_read  = 1'b1;
    addr_in = 32'h00000100;
    m_rdata = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp || addr_out !== 32'h00000100) begin
      n_fail++; $display("FAIL mem_load: got %h/%h want %h/00000100", r_wdata, addr_out, exp);
    end
    @(negedge clk);
    idle();
    m_write = 1'b1;
    r_rdata = 32'h00000055;
    #1;
    n_tests++;
    if (mem_we !== 1'b1 || write_data !== 32'h00000055) begin
      n_fail++; $display("FAIL mem_store: we=%b wd=%h want 1/00000055", mem_we, write_data);
    end
    @(negedge clk);
    idle();
    r_rdata = 32'h00000055;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || write_data !== 32'h0) begin
      n_fail++; $display("FAIL mem_idle: we=%b wd=%h want 0/00000000", mem_we, write_data);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    idle();
    io_read = 1'b1;
    addr_in = 32'hFFFFFC70;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp || io_err !== 1'b0) begin
      n_fail++; $display("FAIL err_read_data: got %h err=%b want %h err=0", r_wdata, io_err, exp);
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (io_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", io_err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (io_err !== 1'b0) begin
      n_fail++; $display("FAIL err_rst: got %b want 0", io_err);
    end
    // Writing a read-only offset is an error too, and leaves the LED alone.
    @(negedge clk);
    io_write = 1'b1;
    addr_in  = Base + 32'h2;
    r_rdata  = 32'h0000BEEF;
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (io_err !== 1'b1 || led_out !== 16'h0) begin
      n_fail++; $display("FAIL err_ro_write: err=%b led=%h want 1/0000", io_err, led_out);
    end
  endtask

  task automatic test_cyccnt();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MEMIO_CYCCNT_EN
    // Released at this negedge; the counter is 0 until the next rising edge.
    repeat (2) @(negedge clk);
    io_read = 1'b1;
    addr_in = Base + 32'h8;
    exp_q.push_back(32'd2);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL cyc_first: got %h want %h", r_wdata, exp);
    end
    repeat (3) @(negedge clk);
    exp_q.push_back(32'd5);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp || io_err !== 1'b0) begin
      n_fail++; $display("FAIL cyc_delta: got %h err=%b want %h err=0", r_wdata, io_err, exp);
    end
`else
    @(negedge clk);
    io_read = 1'b1;
    addr_in = Base + 32'h8;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (r_wdata !== exp) begin
      n_fail++; $display("FAIL cyc_unmapped_data: got %h want %h", r_wdata, exp);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (io_err !== 1'b1) begin
      n_fail++; $display("FAIL cyc_unmapped_err: got %b want 1", io_err);
    end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_rst_mid_debounce();
    @(negedge clk);
    idle();
    btn_confirm = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    btn_confirm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    read_status(32'h0, "rst_mid_debounce");
  endtask

  initial begin
    test_reset();
    test_led();
    test_switch_idx();
    test_debounce();
    test_flag_coincide();
    test_mem();
    test_err();
    test_cyccnt();
    test_rst_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
